// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with operand forwarding, single-cycle ALU,
// iterative multiply/divide unit (HI/LO) and the EX/MEM pipeline register.
// Build option: define EX_MD_DIV_EN to include the radix-2 divider;
// without it DIV/DIVU retire in one cycle and leave HI/LO unchanged.
// Ports:
//   clk, reset (async, active-high)
//   ID/EX in : in_valid, rs/rt addr+data, imm, shamt, alu_src1/2, alu_op,
//              branch, wr_addr, reg_write, mem_read, mem_write
//   MEM/WB in: wb_addr, wb_data, wb_we
//   hazard   : flush, stall_in (in), stall_out (out)
//   outputs  : branch_taken (comb), exm_* (EX/MEM register)
module ex_stage_md #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    localparam int SH_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [SH_W-1:0]   shamt,
    input  logic              alu_src1,
    input  logic              alu_src2,
    input  logic [4:0]        alu_op,
    input  logic              branch,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_we,
    input  logic              flush,
    input  logic              stall_in,
    output logic              stall_out,
    output logic              branch_taken,
    output logic              exm_valid,
    output logic [DATA_W-1:0] exm_result,
    output logic [DATA_W-1:0] exm_store_data,
    output logic [REG_AW-1:0] exm_wr_addr,
    output logic              exm_reg_write,
    output logic              exm_mem_read,
    output logic              exm_mem_write
);

`ifdef EX_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam int CNT_W = SH_W + 1;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_EQ    = 5'd17;
    localparam logic [4:0] OP_NE    = 5'd18;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    md_state_t state, state_nxt;

    logic [DATA_W-1:0] fwd_rs, fwd_rt;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] alu_res;
    logic [SH_W-1:0]   sh;
    logic              exm_src_ok;

    logic [DATA_W-1:0] hi_q, lo_q;
    logic [DATA_W-1:0] hi_nxt, lo_nxt;
    logic [DATA_W-1:0] p_hi, p_lo, md_b, a_raw;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [CNT_W-1:0]  cnt;
    logic              md_div, neg_a, neg_b;

    logic op_mul, op_div, op_md_any, md_op, md_sgn;
    logic md_issue, md_stall, md_wr;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi, mul_lo;
    logic [DATA_W:0]     div_sh, div_diff;
    logic                div_ok;
    logic [DATA_W-1:0]   div_hi, div_lo;
    logic [2*DATA_W-1:0] prod_raw, prod;
    logic [DATA_W-1:0]   quo, rem;

    // EX/MEM feeds back only when its result is already known (not a load)
    assign exm_src_ok = exm_valid & exm_reg_write & ~exm_mem_read
                      & (exm_wr_addr != '0);

    always_comb begin
        fwd_rs = rs_data;
        if (exm_src_ok && exm_wr_addr == rs_addr) begin
            fwd_rs = exm_result;
        end else if (wb_we && wb_addr != '0 && wb_addr == rs_addr) begin
            fwd_rs = wb_data;
        end
        fwd_rt = rt_data;
        if (exm_src_ok && exm_wr_addr == rt_addr) begin
            fwd_rt = exm_result;
        end else if (wb_we && wb_addr != '0 && wb_addr == rt_addr) begin
            fwd_rt = wb_data;
        end
    end

    assign op_a = alu_src1 ? {{(DATA_W-SH_W){1'b0}}, shamt} : fwd_rs;
    assign op_b = alu_src2 ? imm : fwd_rt;
    assign sh   = op_a[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLL:  alu_res = op_b << sh;
            OP_SRL:  alu_res = op_b >> sh;
            OP_SRA:  alu_res = $unsigned($signed(op_b) >>> sh);
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, (op_a == op_b)};
            OP_NE:   alu_res = {{(DATA_W-1){1'b0}}, (op_a != op_b)};
            default: alu_res = '0;
        endcase
    end

    assign branch_taken = in_valid & branch & alu_res[0] & ~flush;

    assign op_mul    = (alu_op == OP_MULT) | (alu_op == OP_MULTU);
    assign op_div    = (alu_op == OP_DIV) | (alu_op == OP_DIVU);
    assign op_md_any = op_mul | op_div;
    assign md_op     = op_mul | (DIV_EN & op_div);
    assign md_sgn    = (alu_op == OP_MULT) | (alu_op == OP_DIV);

    assign md_issue  = in_valid & ~flush & md_op;
    assign md_stall  = ((state == MD_IDLE) & md_issue) | (state == MD_BUSY);
    assign stall_out = stall_in | md_stall;
    assign md_wr     = (state == MD_DONE) & ~flush & ~stall_in;

    assign mag_a = (md_sgn & op_a[DATA_W-1]) ? -op_a : op_a;
    assign mag_b = (md_sgn & op_b[DATA_W-1]) ? -op_b : op_b;

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: if (md_issue) state_nxt = MD_BUSY;
            MD_BUSY: begin
                if (flush) state_nxt = MD_IDLE;
                else if (cnt == CNT_W'(1)) state_nxt = MD_DONE;
            end
            MD_DONE: if (flush || !stall_in) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else state <= state_nxt;
    end

    // shift-add: {p_hi,p_lo} holds partial product above remaining multiplier
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, md_b} : '0);
    assign mul_hi  = mul_sum[DATA_W:1];
    assign mul_lo  = {mul_sum[0], p_lo[DATA_W-1:1]};

    // restoring divide: p_hi = partial remainder, p_lo shifts dividend out
    // and quotient bits in
    assign div_sh   = {p_hi, p_lo[DATA_W-1]};
    assign div_diff = div_sh - {1'b0, md_b};
    assign div_ok   = ~div_diff[DATA_W];
    assign div_hi   = div_ok ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
    assign div_lo   = {p_lo[DATA_W-2:0], div_ok};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            md_b   <= '0;
            a_raw  <= '0;
            md_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else if (state == MD_IDLE && md_issue) begin
            cnt    <= CNT_W'(DATA_W);
            p_hi   <= '0;
            p_lo   <= mag_a;
            md_b   <= mag_b;
            a_raw  <= op_a;
            md_div <= DIV_EN & op_div;
            neg_a  <= md_sgn & op_a[DATA_W-1];
            neg_b  <= md_sgn & op_b[DATA_W-1];
        end else if (state == MD_BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (md_div) begin
                p_hi <= div_hi;
                p_lo <= div_lo;
            end else begin
                p_hi <= mul_hi;
                p_lo <= mul_lo;
            end
        end
    end

    // sign fix-up; MIN / -1 falls out naturally as quotient MIN, rem 0
    assign prod_raw = {p_hi, p_lo};
    assign prod     = (neg_a ^ neg_b) ? -prod_raw : prod_raw;
    assign quo      = (neg_a ^ neg_b) ? -p_lo : p_lo;
    assign rem      = neg_a ? -p_hi : p_hi;

    always_comb begin
        hi_nxt = prod[2*DATA_W-1:DATA_W];
        lo_nxt = prod[DATA_W-1:0];
        if (md_div) begin
            if (md_b == '0) begin
                hi_nxt = a_raw;
                lo_nxt = '1;
            end else begin
                hi_nxt = rem;
                lo_nxt = quo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_wr) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exm_valid      <= 1'b0;
            exm_result     <= '0;
            exm_store_data <= '0;
            exm_wr_addr    <= '0;
            exm_reg_write  <= 1'b0;
            exm_mem_read   <= 1'b0;
            exm_mem_write  <= 1'b0;
        end else if (!stall_in) begin
            if (flush || md_stall || !in_valid) begin
                exm_valid      <= 1'b0;
                exm_result     <= '0;
                exm_store_data <= '0;
                exm_wr_addr    <= '0;
                exm_reg_write  <= 1'b0;
                exm_mem_read   <= 1'b0;
                exm_mem_write  <= 1'b0;
            end else begin
                exm_valid      <= 1'b1;
                exm_result     <= alu_res;
                exm_store_data <= fwd_rt;
                exm_wr_addr    <= wr_addr;
                // MD ops only update HI/LO, never the register file
                exm_reg_write  <= reg_write & ~op_md_any;
                exm_mem_read   <= mem_read;
                exm_mem_write  <= mem_write;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: scoreboard bench for ex_stage_md (DATA_W = 32).
// Directed vectors; a monitor pops expected EX/MEM captures and compares.
module tb_ex_stage_md;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_EQ    = 5'd17;
    localparam logic [4:0] OP_NE    = 5'd18;
`ifdef EX_MD_DIV_EN
    localparam logic [4:0] OP_DIVU  = 5'd14;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  rs_addr, rt_addr, wr_addr, wb_addr;
    logic [31:0] rs_data, rt_data, imm, wb_data;
    logic [4:0]  shamt;
    logic        alu_src1, alu_src2, branch;
    logic [4:0]  alu_op;
    logic        reg_write, mem_read, mem_write, wb_we;
    logic        flush, stall_in;
    logic        stall_out, branch_taken;
    logic        exm_valid;
    logic [31:0] exm_result, exm_store_data;
    logic [4:0]  exm_wr_addr;
    logic        exm_reg_write, exm_mem_read, exm_mem_write;

    int checks = 0;
    int errors = 0;

    logic [72:0] exp_q[$];
    string       nm_q[$];

    logic [31:0] hi_old, lo_old;

    logic [4:0]  t_op [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                               5'd9, 5'd10, 5'd17, 5'd18, 5'd19, 5'd31};
    logic [31:0] t_res[12] = '{32'h8000102C, 32'h7FFFF1B4, 32'h00000030,
                               32'h80000FFC, 32'h80000FCC, 32'h7FFFF003,
                               32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0};
    logic [4:0]  s_op [3]  = '{OP_SLL, OP_SRL, OP_SRA};
    logic [31:0] s_res[3]  = '{32'h00000F00, 32'h0800000F, 32'hF800000F};

    always #5 clk = ~clk;

    ex_stage_md #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .shamt(shamt),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
        .branch(branch), .wr_addr(wr_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we),
        .flush(flush), .stall_in(stall_in),
        .stall_out(stall_out), .branch_taken(branch_taken),
        .exm_valid(exm_valid), .exm_result(exm_result),
        .exm_store_data(exm_store_data), .exm_wr_addr(exm_wr_addr),
        .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read),
        .exm_mem_write(exm_mem_write)
    );

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_ins(input logic [4:0] op,
                           input logic [4:0] ra, input logic [31:0] da,
                           input logic [4:0] rb, input logic [31:0] db,
                           input logic [4:0] wa);
        in_valid  = 1'b1;
        alu_op    = op;
        rs_addr   = ra;
        rs_data   = da;
        rt_addr   = rb;
        rt_data   = db;
        wr_addr   = wa;
        reg_write = 1'b1;
        alu_src1  = 1'b0;
        alu_src2  = 1'b0;
        imm       = '0;
        shamt     = '0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] res,
                              input logic [31:0] st, input logic [4:0] wa,
                              input logic rw, input logic mr, input logic mw);
        exp_q.push_back({res, st, wa, rw, mr, mw});
        nm_q.push_back(nm);
    endtask

    // hold the instruction until accepted; n = cycles stall_out was high
    task automatic go(output int n);
        n = 0;
        @(negedge clk);
        while (stall_out && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (stall_out) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: stall_out stuck at 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        branch   = 1'b0;
    endtask

    task automatic mf(input logic hi, input logic [31:0] ev, input string nm);
        int n;
        set_ins(hi ? OP_MFHI : OP_MFLO, 5'd0, '0, 5'd0, '0, 5'd20);
        expect_out(nm, ev, 32'h0, 5'd20, 1'b1, 1'b0, 1'b0);
        go(n);
    endtask

    initial begin : monitor
        logic        st, rr;
        logic [72:0] got, e;
        string       nm;
        forever begin
            @(negedge clk);
            st = stall_in;
            rr = reset;
            @(posedge clk);
            #3;
            if (!st && !rr && !reset && exm_valid) begin
                got = {exm_result, exm_store_data, exm_wr_addr,
                       exm_reg_write, exm_mem_read, exm_mem_write};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_capture: got %h expected none",
                             got);
                end else begin
                    e  = exp_q.pop_front();
                    nm = nm_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", nm, got, e);
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        reset    = 1'b1;
        stall_in = 1'b1;
        flush    = 1'b0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        set_ins(OP_ADD, 5'd0, '0, 5'd0, '0, 5'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_exm_valid", 32'(exm_valid), 32'h0);
        check("rst_exm_result", exm_result, 32'h0);
        check("rst_exm_store", exm_store_data, 32'h0);
        check("rst_exm_ctl", 32'({exm_wr_addr, exm_reg_write,
                                  exm_mem_read, exm_mem_write}), 32'h0);
        check("rst_stall_follow_1", 32'(stall_out), 32'h1);
        stall_in = 1'b0;
        #1;
        check("rst_stall_follow_0", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        mf(1'b1, 32'h0, "hi_reset");
        mf(1'b0, 32'h0, "lo_reset");

        // forwarding priority
        set_ins(OP_ADD, 5'd0, '0, 5'd0, '0, 5'd5);
        alu_src2 = 1'b1;
        imm = 32'h11;
        expect_out("wr_r5", 32'h11, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
        go(n);
        set_ins(OP_ADD, 5'd5, 32'h99, 5'd0, '0, 5'd7);
        wb_addr = 5'd5;
        wb_data = 32'h22;
        wb_we = 1'b1;
        expect_out("fwd_exm_wins", 32'h11, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
        go(n);
        set_ins(OP_ADD, 5'd5, 32'h99, 5'd5, 32'h98, 5'd8);
        expect_out("fwd_wb", 32'h44, 32'h22, 5'd8, 1'b1, 1'b0, 1'b0);
        go(n);
        wb_we = 1'b0;
        set_ins(OP_ADD, 5'd0, '0, 5'd0, '0, 5'd0);
        alu_src2 = 1'b1;
        imm = 32'h33;
        expect_out("wr_r0", 32'h33, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0);
        go(n);
        set_ins(OP_ADD, 5'd0, '0, 5'd0, '0, 5'd9);
        wb_addr = 5'd0;
        wb_data = 32'h44;
        wb_we = 1'b1;
        expect_out("no_fwd_r0", 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        go(n);
        wb_we = 1'b0;
        set_ins(OP_ADD, 5'd0, '0, 5'd0, '0, 5'd6);
        alu_src2 = 1'b1;
        imm = 32'h100;
        mem_read = 1'b1;
        expect_out("load", 32'h100, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
        go(n);
        set_ins(OP_ADD, 5'd6, 32'h5, 5'd0, '0, 5'd9);
        expect_out("no_fwd_load", 32'h5, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        go(n);
        set_ins(OP_ADD, 5'd1, 32'h200, 5'd9, 32'h77, 5'd0);
        reg_write = 1'b0;
        mem_write = 1'b1;
        alu_src2 = 1'b1;
        imm = 32'h4;
        expect_out("store_fwd", 32'h204, 32'h5, 5'd0, 1'b0, 1'b0, 1'b1);
        go(n);

        // ALU table
        for (int i = 0; i < 12; i++) begin
            set_ins(t_op[i], 5'd1, 32'h800000F0, 5'd2, 32'h00000F3C, 5'd20);
            expect_out($sformatf("alu_op%0d", t_op[i]), t_res[i],
                       32'h00000F3C, 5'd20, 1'b1, 1'b0, 1'b0);
            go(n);
        end
        for (int i = 0; i < 3; i++) begin
            set_ins(s_op[i], 5'd1, 32'h0, 5'd2, 32'h800000F0, 5'd20);
            alu_src1 = 1'b1;
            shamt = 5'd4;
            expect_out($sformatf("shift_op%0d", s_op[i]), s_res[i],
                       32'h800000F0, 5'd20, 1'b1, 1'b0, 1'b0);
            go(n);
        end

        // multiply
        set_ins(OP_MULT, 5'd1, 32'hFFFFFFFF, 5'd2, 32'h2, 5'd20);
        expect_out("mult_retire", 32'h0, 32'h2, 5'd20, 1'b0, 1'b0, 1'b0);
        go(n);
        check("mult_stall_cycles", 32'(n), 32'd33);
        mf(1'b1, 32'hFFFFFFFF, "mult_hi");
        mf(1'b0, 32'hFFFFFFFE, "mult_lo");

`ifdef EX_MD_DIV_EN
        set_ins(OP_DIV, 5'd1, 32'hFFFFFFF9, 5'd2, 32'h2, 5'd20);
        expect_out("div_retire", 32'h0, 32'h2, 5'd20, 1'b0, 1'b0, 1'b0);
        go(n);
        check("div_stall_cycles", 32'(n), 32'd33);
        mf(1'b0, 32'hFFFFFFFD, "div_lo");
        mf(1'b1, 32'hFFFFFFFF, "div_hi");
        set_ins(OP_DIVU, 5'd1, 32'h9, 5'd2, 32'h0, 5'd20);
        expect_out("divu0_retire", 32'h0, 32'h0, 5'd20, 1'b0, 1'b0, 1'b0);
        go(n);
        mf(1'b0, 32'hFFFFFFFF, "divu0_lo");
        mf(1'b1, 32'h9, "divu0_hi");
        set_ins(OP_DIV, 5'd1, 32'h80000000, 5'd2, 32'hFFFFFFFF, 5'd20);
        expect_out("divmin_retire", 32'h0, 32'hFFFFFFFF, 5'd20,
                   1'b0, 1'b0, 1'b0);
        go(n);
        mf(1'b0, 32'h80000000, "divmin_lo");
        mf(1'b1, 32'h0, "divmin_hi");
        hi_old = 32'h0;
        lo_old = 32'h80000000;
`else
        set_ins(OP_DIV, 5'd1, 32'd100, 5'd2, 32'd7, 5'd20);
        expect_out("div_off_retire", 32'h0, 32'd7, 5'd20, 1'b0, 1'b0, 1'b0);
        go(n);
        check("div_off_no_stall", 32'(n), 32'd0);
        mf(1'b1, 32'hFFFFFFFF, "div_off_hi");
        mf(1'b0, 32'hFFFFFFFE, "div_off_lo");
        hi_old = 32'hFFFFFFFF;
        lo_old = 32'hFFFFFFFE;
`endif

        // flush on cycle 10 of a MULTU
        set_ins(OP_MULTU, 5'd1, 32'h3, 5'd2, 32'h5, 5'd20);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_busy_stall", 32'(stall_out), 32'h1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_stall_drop", 32'(stall_out), 32'h0);
        check("flush_bubble", 32'(exm_valid), 32'h0);
        @(posedge clk);
        #1;
        mf(1'b1, hi_old, "flush_hi_kept");
        mf(1'b0, lo_old, "flush_lo_kept");

        // branch decision
        set_ins(OP_EQ, 5'd1, 32'h1234, 5'd2, 32'h1234, 5'd0);
        reg_write = 1'b0;
        branch = 1'b1;
        #1;
        check("beq_taken", 32'(branch_taken), 32'h1);
        flush = 1'b1;
        #1;
        check("beq_flushed", 32'(branch_taken), 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        set_ins(OP_NE, 5'd1, 32'h1234, 5'd2, 32'h1234, 5'd0);
        reg_write = 1'b0;
        branch = 1'b1;
        #1;
        check("bne_not_taken", 32'(branch_taken), 32'h0);
        expect_out("bne_retire", 32'h0, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0);
        go(n);

        // downstream hold
        set_ins(OP_ADD, 5'd1, 32'h10, 5'd2, 32'h20, 5'd21);
        expect_out("hold_add", 32'h30, 32'h20, 5'd21, 1'b1, 1'b0, 1'b0);
        go(n);
        stall_in = 1'b1;
        set_ins(OP_SUB, 5'd1, 32'h50, 5'd2, 32'h8, 5'd22);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("hold_result", exm_result, 32'h30);
            check("hold_wr_addr", 32'(exm_wr_addr), 32'd21);
            check("hold_stall_out", 32'(stall_out), 32'h1);
        end
        stall_in = 1'b0;
        expect_out("after_hold_sub", 32'h48, 32'h8, 5'd22, 1'b1, 1'b0, 1'b0);
        go(n);

        // reset in the middle of a multiply
        set_ins(OP_ADD, 5'd1, 32'h5, 5'd2, 32'h6, 5'd23);
        expect_out("pre_reset_add", 32'hB, 32'h6, 5'd23, 1'b1, 1'b0, 1'b0);
        go(n);
        stall_in = 1'b1;
        set_ins(OP_MULT, 5'd1, 32'h7, 5'd2, 32'h9, 5'd20);
        repeat (5) @(posedge clk);
        #1;
        check("busy_hold_result", exm_result, 32'hB);
        reset = 1'b1;
        in_valid = 1'b0;
        stall_in = 1'b0;
        #1;
        check("midrst_valid", 32'(exm_valid), 32'h0);
        check("midrst_result", exm_result, 32'h0);
        check("midrst_store", exm_store_data, 32'h0);
        check("midrst_ctl", 32'({exm_wr_addr, exm_reg_write,
                                 exm_mem_read, exm_mem_write}), 32'h0);
        check("midrst_stall", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mf(1'b1, 32'h0, "midrst_hi");
        mf(1'b0, 32'h0, "midrst_lo");

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Parametrised next-generation execute stage for the 5-stage pipeline; owns the EX/MEM pipeline register.
- Operand forwarding:
  - EX/MEM source is internal (fed back from its own register).
  - MEM/WB source is external.
- Single-cycle ALU plus an iterative multiply/divide unit writing HI/LO.
- Pipeline interface: stall/flush handshake toward the hazard unit.

Parameters:
- DATA_W, 32, datapath width; must be a power of two, at least 8.
- REG_AW, 5, register address width.
- SH_W, $clog2(DATA_W), shift-amount width; localparam, derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID/EX holds a valid instruction.
- rs_addr, rt_addr  in  REG_AW  source register numbers.
- rs_data, rt_data  in  DATA_W  register-file read data.
- imm  in  DATA_W  extended immediate.
- shamt  in  SH_W  shift amount.
- alu_src1  in  1  1 = operand A is zero-extended shamt; 0 = forwarded rs.
- alu_src2  in  1  1 = operand B is imm; 0 = forwarded rt.
- alu_op  in  5  operation code (see Behaviour).
- branch  in  1  instruction is a conditional branch.
- wr_addr  in  REG_AW  resolved destination register.
- reg_write, mem_read, mem_write  in  1  control bits passed to MEM/WB.
- wb_addr  in  REG_AW  MEM/WB destination register.
- wb_data  in  DATA_W  MEM/WB write data.
- wb_we  in  1  MEM/WB register write enable.
- flush  in  1  kill the instruction currently in EX.
- stall_in  in  1  downstream hold.
- stall_out  out  1  upstream must hold ID/EX and PC.
- branch_taken  out  1  combinational branch decision.
- exm_valid  out  1  EX/MEM register: instruction valid.
- exm_result  out  DATA_W  EX/MEM register: ALU or HI/LO result.
- exm_store_data  out  DATA_W  EX/MEM register: forwarded rt.
- exm_wr_addr  out  REG_AW  EX/MEM register: destination register.
- exm_reg_write, exm_mem_read, exm_mem_write  out  1  EX/MEM register: control bits.

Behaviour:

Reset:
- All exm_* outputs are 0.
- HI and LO are 0.
- MD FSM is in IDLE.
- stall_out follows stall_in.

Forwarding (rs and rt independently):
1. EX/MEM source wins when exm_valid & exm_reg_write & !exm_mem_read & exm_wr_addr != 0 & address match.
2. Otherwise the MEM/WB source wins when wb_we & wb_addr != 0 & address match.
3. Otherwise the register-file data is used.
- Register 0 is never forwarded.
- Store data uses forwarded rt.

alu_op codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLL, 7 SRL, 8 SRA: shift B by A[SH_W-1:0].
- 9 SLT (signed), 10 SLTU (unsigned).
- 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
- 15 MFHI, 16 MFLO.
- 17 EQ: result 1 if A == B.
- 18 NE: result 1 if A != B.
- Any other code: result 0.
- Arithmetic wraps mod 2^DATA_W; there is no overflow trap.

branch_taken:
- branch_taken = in_valid & branch & result[0] & !flush.
- It is independent of stall.

MD unit FSM:
- Issue condition (md_issue): in_valid & !flush & op in 11..14.
- IDLE -> BUSY on md_issue: latch forwarded A/B and sign mode; cnt = DATA_W.
- BUSY: one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes); cnt decrements; at cnt == 1 go to DONE.
- DONE: apply sign correction and write HI/LO at the clock edge leaving DONE (requires !stall_in); return to IDLE.
- Multiply: HI:LO = full 2*DATA_W product.
- Divide: LO = quotient, HI = remainder. Signed divide truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend.
- Signed MIN / -1: LO = MIN, HI = 0.
- stall_out = stall_in | (state == IDLE & md_issue) | (state == BUSY).
- Stall length: an MD op holds the pipeline for exactly DATA_W+1 cycles, then retires in DONE with reg_write forced 0.
- flush in BUSY or DONE: abort to IDLE; HI/LO unchanged; a bubble enters EX/MEM.
- MFHI/MFLO in the instruction immediately after an MD op see the new HI/LO (no extra stall).

EX/MEM register:
- stall_in = 1: hold all exm_* values.
- Else if flush, MD stall active, or !in_valid: load a bubble (exm_valid = 0; all control bits 0; data don't-care, driven 0).
- Else: capture result and controls; exm_valid = 1.

Optional Feature:
- Macro: EX_MD_DIV_EN.
- Defined: DIV/DIVU are implemented as described above.
- Undefined:
  - Divider datapath is removed.
  - DIV/DIVU retire in one cycle with no stall.
  - HI/LO unchanged.
  - MULT/MULTU are unaffected.

Test Plan:
- Forward priority: EX/MEM writes r5 = 0x11, MEM/WB wb_addr = 5 with data 0x22; ADD r5 + r0 -> exm_result = 0x11. Repeat with destination r0 -> r0 operand reads 0 from the register file.
- MULT 0xFFFFFFFF x 2 (DATA_W = 32): stall_out high for exactly 33 cycles; then MFHI -> 0xFFFFFFFF, MFLO -> 0xFFFFFFFE.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 9 / 0 -> LO = 0xFFFFFFFF, HI = 9.
- DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- flush asserted on cycle 10 of a MULTU: FSM returns to IDLE, stall_out drops the next cycle, HI/LO keep their old values, exm_valid = 0.
- stall_in held for 3 cycles with a valid ADD in EX: exm_* hold steady; reset pulsed mid-BUSY -> all outputs 0 immediately.
- BEQ-style EQ with rs = rt = 0x1234 and branch = 1 -> branch_taken = 1; with flush = 1 -> branch_taken = 0.
